// File: rtl/pe_pkg.sv
// Shared types and constants for the PE array result path.
package pe_pkg;

    localparam int unsigned PE_ARRAY_SIZE = 8;
    localparam int unsigned PE_ACC_WIDTH  = 16;

    // Cycles in one tile's diagonal wavefront (k = 0 .. 2N-2).
    localparam int unsigned CYCLE_LENGTH = 2 * PE_ARRAY_SIZE - 1;

    typedef logic signed [PE_ACC_WIDTH-1:0] acc_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } collector_state_t;

endpackage

// File: rtl/pe_row_fifo.sv
// First-word-fall-through row FIFO; a push while full is dropped unless a pop frees the slot.
module pe_row_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Status, accepted push/pop and next pointers; head reads as zero when empty
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; when full with a pop, the freed head slot is the write slot
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pe_result_collector.sv
// De-skews the PE array's diagonal result wavefront into row vectors and queues them for the writer.
module pe_result_collector
    import pe_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE             = PE_ARRAY_SIZE,
    parameter int unsigned ARRAY_SIZE_WIDTH       = $clog2(ARRAY_SIZE),
    parameter int unsigned ACCUMULATOR_DATA_WIDTH = PE_ACC_WIDTH,
    parameter int unsigned FIFO_DEPTH             = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]    results_in,
    output logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]    results_out,
    output logic [ARRAY_SIZE_WIDTH-1:0]                          out_row,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 overflow,
    output logic                                                 start_err
);

    localparam int unsigned   CYC_LEN = 2 * ARRAY_SIZE - 1;
    localparam int unsigned   KW      = $clog2(CYC_LEN);
    localparam int unsigned   EW      = ARRAY_SIZE * ACCUMULATOR_DATA_WIDTH + ARRAY_SIZE_WIDTH;
    localparam logic [KW-1:0] K_LAST  = KW'(CYC_LEN - 1);
    localparam logic [KW-1:0] K_PUSH  = KW'(ARRAY_SIZE - 1);

    collector_state_t state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             in_collect, k_last, start_acc, start_bad, push;
    logic             done_q, overflow_q, start_err_q;
    logic             fifo_full, fifo_empty, pop;

    logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0] aligned;
    logic [ARRAY_SIZE_WIDTH-1:0]                       push_row;
    logic [EW-1:0]                                     fifo_wdata, fifo_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a start on the final collect cycle chains straight into the next tile
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (k_q == K_LAST) state_d = start ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: start acceptance, illegal-start detection and push window
    always_comb begin
        in_collect = 1'b0;
        k_last     = 1'b0;
        start_acc  = 1'b0;
        start_bad  = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_acc = start;
            end
            COLLECT: begin
                in_collect = 1'b1;
                k_last     = (k_q == K_LAST);
                start_acc  = start && k_last;
                start_bad  = start && !k_last;
                push       = (k_q >= K_PUSH);
            end
            default: ;
        endcase
    end

    // Wavefront counter; the start cycle itself is k = 0, so COLLECT begins at k = 1
    always_comb begin
        if (start_acc) begin
            k_d = KW'(1);
        end else if (in_collect && !k_last) begin
            k_d = k_q + KW'(1);
        end else begin
            k_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    // Per-lane capture window and de-skew staircase: lane c waits N-1-c cycles
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
        logic                              lane_en;
        logic [ACCUMULATOR_DATA_WIDTH-1:0] lane_in;

        if (c == 0) begin : g_win0
            assign lane_en = start_acc || (in_collect && (k_q <= K_PUSH));
        end else begin : g_winc
            assign lane_en = in_collect && (k_q >= KW'(c)) && (k_q <= KW'(c + ARRAY_SIZE - 1));
        end

        assign lane_in = lane_en ? results_in[c] : '0;

        if (c == ARRAY_SIZE - 1) begin : g_direct
            assign aligned[c] = lane_in;
        end else begin : g_delay
            localparam int unsigned DEPTH = ARRAY_SIZE - 1 - c;
            logic [DEPTH-1:0][ACCUMULATOR_DATA_WIDTH-1:0] dl_q;

            // Delay line shifts every cycle regardless of FSM state
            always_ff @(posedge clk) begin
                if (rst) begin
                    dl_q <= '0;
                end else begin
                    dl_q[0] <= lane_in;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        dl_q[i] <= dl_q[i-1];
                    end
                end
            end

            assign aligned[c] = dl_q[DEPTH-1];
        end
    end

    assign push_row   = ARRAY_SIZE_WIDTH'(k_q - K_PUSH);
    assign fifo_wdata = {push_row, aligned};
    assign pop        = out_valid && out_ready;

    pe_row_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Done pulse and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            done_q <= k_last;
            if (push && fifo_full && !pop) overflow_q <= 1'b1;
            if (start_bad) start_err_q <= 1'b1;
        end
    end

    assign {out_row, results_out} = fifo_rdata;
    assign out_valid = !fifo_empty;
    assign busy      = in_collect || !fifo_empty;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: tile-level reference model against FIFO depths 8 and 4.
module tb_pe_result_collector;
    import pe_pkg::*;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int RW = 3;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
    typedef struct { int s; mat_t m; } tile_t;
    typedef struct { int row; vec_t v; } row_t;

    logic clk, rst, start, out_ready;
    vec_t results_in;
    vec_t res8, res4;
    logic [RW-1:0] row8, row4;
    logic valid8, valid4, busy8, busy4, done8, done4, ovf8, ovf4, err8, err4;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    bit zero_fill = 0;
    mat_t next_mat;
    tile_t tiles[$];
    row_t q8[$];
    row_t q4[$];
    bit ovf8_e, ovf4_e, err_e, done_e;

    pe_result_collector #(.ARRAY_SIZE(N), .ARRAY_SIZE_WIDTH(RW), .ACCUMULATOR_DATA_WIDTH(W), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .results_in(results_in), .results_out(res8), .out_row(row8),
        .out_valid(valid8), .out_ready(out_ready), .busy(busy8), .done(done8), .overflow(ovf8), .start_err(err8));

    pe_result_collector #(.ARRAY_SIZE(N), .ARRAY_SIZE_WIDTH(RW), .ACCUMULATOR_DATA_WIDTH(W), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .results_in(results_in), .results_out(res4), .out_row(row4),
        .out_valid(valid4), .out_ready(out_ready), .busy(busy4), .done(done4), .overflow(ovf4), .start_err(err4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit collecting(int t);
        foreach (tiles[i]) if (t > tiles[i].s && t <= tiles[i].s + CYCLE_LENGTH - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m[r][c] = W'($urandom);
        return m;
    endfunction

    // One clock of the tile-level model: accept start, drive lanes, push/pop rows, then advance.
    task automatic tick();
        bit acc, pushing, done_next, pop8, pop4;
        int lr, k;
        row_t pe;
        if (rst) begin
            results_in = vec_t'({$urandom, $urandom, $urandom, $urandom});
            @(posedge clk); #2;
            tiles.delete(); q8.delete(); q4.delete();
            ovf8_e = 0; ovf4_e = 0; err_e = 0; done_e = 0; cyc = 0;
            return;
        end
        if (start) begin
            acc = 1'b1;
            foreach (tiles[i]) if (cyc > tiles[i].s && cyc < tiles[i].s + CYCLE_LENGTH - 1) acc = 1'b0;
            if (acc) begin
                tile_t t;
                t.s = cyc; t.m = next_mat;
                tiles.push_back(t);
            end else err_e = 1'b1;
        end
        for (int c = 0; c < N; c++) begin
            results_in[c] = zero_fill ? '0 : W'($urandom);
            foreach (tiles[i]) begin
                lr = cyc - tiles[i].s - c;
                if (lr >= 0 && lr < N) results_in[c] = tiles[i].m[lr][c];
            end
        end
        pushing = 0; done_next = 0;
        foreach (tiles[i]) begin
            k = cyc - tiles[i].s;
            if (k >= N - 1 && k <= 2 * N - 2) begin
                pushing = 1; pe.row = k - (N - 1); pe.v = tiles[i].m[k - (N - 1)];
            end
            if (k == 2 * N - 2) done_next = 1;
        end
        pop8 = (q8.size() > 0) && out_ready;
        pop4 = (q4.size() > 0) && out_ready;
        if (pop8) q8.delete(0);
        if (pop4) q4.delete(0);
        if (pushing) begin
            if (q8.size() < 8) q8.push_back(pe); else ovf8_e = 1;
            if (q4.size() < 4) q4.push_back(pe); else ovf4_e = 1;
        end
        @(posedge clk); #2;
        cyc++;
        done_e = done_next;
        while (tiles.size() > 0 && cyc > tiles[0].s + CYCLE_LENGTH - 1) tiles.delete(0);
    endtask

    task automatic do_reset();
        rst = 1; start = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; out_ready = 0;
        tick();
        rst = 0; start = 0;
        n_tests++; if ({valid8, busy8, done8, ovf8, err8, row8} !== '0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {valid8, busy8, done8, ovf8, err8, row8}); end
        n_tests++; if (res8 !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", res8); end
        n_tests++; if ({valid4, busy4, done4, ovf4, err4, row4} !== '0) begin n_fail++; $display("FAIL reset_ctrl4 got=%b exp=0", {valid4, busy4, done4, ovf4, err4, row4}); end
        tick();
        n_tests++; if (busy8 !== 1'b0 || valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b valid=%b exp 0 0", busy8, valid8); end
    endtask

    task automatic test_single_tile();
        int first_valid = -1, done_cyc = -1, busy_fall = -1, rows = 0;
        do_reset();
        zero_fill = 1; out_ready = 1;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) next_mat[r][c] = W'(16 * r + c);
        for (int i = 0; i < 24; i++) begin
            start = (cyc == 0);
            tick();
            start = 0;
            n_tests++; if (valid8 !== (q8.size() > 0)) begin n_fail++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", cyc, valid8, q8.size() > 0); end
            if (q8.size() > 0) begin
                n_tests++; if (row8 !== RW'(q8[0].row) || res8 !== q8[0].v) begin n_fail++; $display("FAIL single_head cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row8, res8, q8[0].row, q8[0].v); end
            end
            n_tests++; if (done8 !== done_e) begin n_fail++; $display("FAIL single_done cyc=%0d got=%b exp=%b", cyc, done8, done_e); end
            n_tests++; if (busy8 !== (collecting(cyc) || q8.size() > 0)) begin n_fail++; $display("FAIL single_busy cyc=%0d got=%b", cyc, busy8); end
            if (valid8 === 1'b1) begin rows++; if (first_valid < 0) first_valid = cyc; end
            if (done8 === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (busy8 === 1'b0 && busy_fall < 0 && cyc > 1) busy_fall = cyc;
        end
        zero_fill = 0;
        n_tests++; if (first_valid != 8) begin n_fail++; $display("FAIL single_first_valid got=%0d exp=8", first_valid); end
        n_tests++; if (rows != 8) begin n_fail++; $display("FAIL single_rows got=%0d exp=8", rows); end
        n_tests++; if (done_cyc != 15) begin n_fail++; $display("FAIL single_done_cycle got=%0d exp=15", done_cyc); end
        n_tests++; if (busy_fall != 16) begin n_fail++; $display("FAIL single_busy_fall got=%0d exp=16", busy_fall); end
    endtask

    task automatic test_signed();
        bit seen2 = 0, seen6 = 0;
        do_reset();
        out_ready = 1;
        next_mat = rand_mat();
        next_mat[2][5] = acc_t'(-32768);
        next_mat[6][1] = acc_t'(32767);
        for (int i = 0; i < 20; i++) begin
            start = (cyc == 0);
            tick();
            start = 0;
            if (q8.size() > 0) begin
                n_tests++; if (row8 !== RW'(q8[0].row) || res8 !== q8[0].v) begin n_fail++; $display("FAIL signed_head cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row8, res8, q8[0].row, q8[0].v); end
            end
            if (valid8 === 1'b1 && row8 === 3'd2) begin
                seen2 = 1;
                n_tests++; if (res8[5] !== 16'h8000) begin n_fail++; $display("FAIL signed_min got=%h exp=8000", res8[5]); end
            end
            if (valid8 === 1'b1 && row8 === 3'd6) begin
                seen6 = 1;
                n_tests++; if (res8[1] !== 16'h7fff) begin n_fail++; $display("FAIL signed_max got=%h exp=7fff", res8[1]); end
            end
        end
        n_tests++; if (!(seen2 && seen6)) begin n_fail++; $display("FAIL signed_rows_seen got=%b%b exp=11", seen2, seen6); end
    endtask

    task automatic test_backpressure();
        int rows8 = 0, rows4 = 0;
        do_reset();
        out_ready = 0;
        next_mat = rand_mat();
        for (int i = 0; i < 18; i++) begin
            start = (cyc == 0);
            tick();
            start = 0;
        end
        n_tests++; if (valid8 !== 1'b1 || row8 !== 3'd0 || ovf8 !== 1'b0) begin n_fail++; $display("FAIL bp_hold8 got valid=%b row=%0d ovf=%b exp 1 0 0", valid8, row8, ovf8); end
        n_tests++; if (valid4 !== 1'b1 || row4 !== 3'd0 || ovf4 !== 1'b1) begin n_fail++; $display("FAIL bp_hold4 got valid=%b row=%0d ovf=%b exp 1 0 1", valid4, row4, ovf4); end
        n_tests++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL bp_busy got=%b exp=1", busy8); end
        out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (q8.size() > 0) begin
                n_tests++; if (row8 !== RW'(q8[0].row) || res8 !== q8[0].v) begin n_fail++; $display("FAIL bp_head8 cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row8, res8, q8[0].row, q8[0].v); end
            end
            if (q4.size() > 0) begin
                n_tests++; if (row4 !== RW'(q4[0].row) || res4 !== q4[0].v) begin n_fail++; $display("FAIL bp_head4 cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row4, res4, q4[0].row, q4[0].v); end
            end
            if (valid8 === 1'b1) rows8++;
            if (valid4 === 1'b1) rows4++;
            tick();
        end
        n_tests++; if (rows8 != 8) begin n_fail++; $display("FAIL bp_rows8 got=%0d exp=8", rows8); end
        n_tests++; if (rows4 != 4) begin n_fail++; $display("FAIL bp_rows4 got=%0d exp=4", rows4); end
        n_tests++; if (ovf8 !== 1'b0 || ovf4 !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got ovf8=%b ovf4=%b exp 0 1", ovf8, ovf4); end
    endtask

    task automatic test_back_to_back();
        int rows = 0, dones = 0, done1 = -1, done2 = -1;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 34; i++) begin
            start = (cyc == 0) || (cyc == 2 * N - 2);
            if (start) next_mat = rand_mat();
            tick();
            start = 0;
            n_tests++; if (valid8 !== (q8.size() > 0)) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, valid8, q8.size() > 0); end
            if (q8.size() > 0) begin
                n_tests++; if (row8 !== RW'(q8[0].row) || res8 !== q8[0].v) begin n_fail++; $display("FAIL b2b_head cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row8, res8, q8[0].row, q8[0].v); end
            end
            n_tests++; if (busy8 !== (collecting(cyc) || q8.size() > 0)) begin n_fail++; $display("FAIL b2b_busy cyc=%0d got=%b", cyc, busy8); end
            if (valid8 === 1'b1) rows++;
            if (done8 === 1'b1) begin dones++; if (done1 < 0) done1 = cyc; else done2 = cyc; end
        end
        n_tests++; if (rows != 16) begin n_fail++; $display("FAIL b2b_rows got=%0d exp=16", rows); end
        n_tests++; if (dones != 2 || done1 != 15 || done2 != 29) begin n_fail++; $display("FAIL b2b_done got n=%0d at %0d,%0d exp 2 at 15,29", dones, done1, done2); end
        n_tests++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL b2b_start_err got=%b exp=0", err8); end
    endtask

    task automatic test_start_err();
        int rows = 0, dones = 0;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 24; i++) begin
            start = (cyc == 0) || (cyc == 5);
            if (start) next_mat = rand_mat();
            tick();
            start = 0;
            n_tests++; if (err8 !== err_e) begin n_fail++; $display("FAIL serr_flag cyc=%0d got=%b exp=%b", cyc, err8, err_e); end
            if (q8.size() > 0) begin
                n_tests++; if (row8 !== RW'(q8[0].row) || res8 !== q8[0].v) begin n_fail++; $display("FAIL serr_head cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row8, res8, q8[0].row, q8[0].v); end
            end
            if (valid8 === 1'b1) rows++;
            if (done8 === 1'b1) dones++;
        end
        n_tests++; if (rows != 8 || dones != 1) begin n_fail++; $display("FAIL serr_tile got rows=%0d dones=%0d exp 8 1", rows, dones); end
        n_tests++; if (err8 !== 1'b1) begin n_fail++; $display("FAIL serr_sticky got=%b exp=1", err8); end
    endtask

    task automatic test_mid_reset();
        int rows = 0;
        do_reset();
        out_ready = 0;
        next_mat = rand_mat();
        for (int i = 0; i < 10; i++) begin
            start = (cyc == 0);
            tick();
            start = 0;
        end
        n_tests++; if (valid8 !== 1'b1 || row8 !== 3'd0 || busy8 !== 1'b1) begin n_fail++; $display("FAIL mrst_pre got valid=%b row=%0d busy=%b exp 1 0 1", valid8, row8, busy8); end
        rst = 1;
        tick();
        rst = 0;
        n_tests++; if ({valid8, busy8, done8} !== 3'b000) begin n_fail++; $display("FAIL mrst_after got=%b exp=000", {valid8, busy8, done8}); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++; if (done8 !== 1'b0 || valid8 !== 1'b0) begin n_fail++; $display("FAIL mrst_quiet cyc=%0d got done=%b valid=%b exp 0 0", cyc, done8, valid8); end
        end
        out_ready = 1;
        next_mat = rand_mat();
        for (int i = 0; i < 20; i++) begin
            start = (i == 0);
            tick();
            start = 0;
            if (q8.size() > 0) begin
                n_tests++; if (row8 !== RW'(q8[0].row) || res8 !== q8[0].v) begin n_fail++; $display("FAIL mrst_head cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row8, res8, q8[0].row, q8[0].v); end
            end
            if (valid8 === 1'b1) rows++;
        end
        n_tests++; if (rows != 8) begin n_fail++; $display("FAIL mrst_rows got=%0d exp=8", rows); end
    endtask

    task automatic test_random();
        int next_start = 0;
        do_reset();
        for (int i = 0; i < 160; i++) begin
            start = (i < 120) && ((cyc == next_start) || ($urandom_range(0, 24) == 0));
            if (start) begin
                next_mat = rand_mat();
                next_start = cyc + 2 * N - 2 + (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6));
            end
            out_ready = (i >= 120) || ($urandom_range(0, 3) != 0);
            tick();
            start = 0;
            n_tests++; if ({valid8, valid4} !== {q8.size() > 0, q4.size() > 0}) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b%b exp=%b%b", cyc, valid8, valid4, q8.size() > 0, q4.size() > 0); end
            if (q8.size() > 0) begin
                n_tests++; if (row8 !== RW'(q8[0].row) || res8 !== q8[0].v) begin n_fail++; $display("FAIL rnd_head8 cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row8, res8, q8[0].row, q8[0].v); end
            end
            if (q4.size() > 0) begin
                n_tests++; if (row4 !== RW'(q4[0].row) || res4 !== q4[0].v) begin n_fail++; $display("FAIL rnd_head4 cyc=%0d got row=%0d %h exp row=%0d %h", cyc, row4, res4, q4[0].row, q4[0].v); end
            end
            n_tests++; if ({done8, done4} !== {done_e, done_e}) begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%b%b exp=%b", cyc, done8, done4, done_e); end
            n_tests++; if ({busy8, busy4} !== {collecting(cyc) || q8.size() > 0, collecting(cyc) || q4.size() > 0}) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b%b", cyc, busy8, busy4); end
            n_tests++; if ({ovf8, ovf4, err8, err4} !== {ovf8_e, ovf4_e, err_e, err_e}) begin n_fail++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {ovf8, ovf4, err8, err4}, {ovf8_e, ovf4_e, err_e, err_e}); end
        end
    endtask

    initial begin
        rst = 1; start = 0; out_ready = 0; results_in = '0;
        test_reset();
        test_single_tile();
        test_signed();
        test_backpressure();
        test_back_to_back();
        test_start_err();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
